// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the write/read channel FSM state types
// used by axil_slave_ctrl.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_MEM,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/axil_chan_reg.sv
// Holding register for one AXI channel payload: captured on the channel
// handshake, cleared once the controller has consumed it.
module axil_chan_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // NOTE: default-assign every always_comb output first so no path infers a latch.
    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end
        if (load_i) begin
            data_d = data_i;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/axil_slave_ctrl.sv
// AXI4-Lite slave bridging to a simple one-cycle-strobe memory port.
// Define AXIL_SLVERR_EN to reject word indices >= DEPTH with SLVERR.
module axil_slave_ctrl
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    output logic [1:0]              S_BRESP,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    output logic                    S_RVALID,
    input  logic                    S_RREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    MEM_WEN,
    output logic [ADDR_WIDTH-1:0]   MEM_AWADDR,
    output logic [DATA_WIDTH/8-1:0] MEM_WSTRB,
    output logic [DATA_WIDTH-1:0]   MEM_WDATA,
    output logic                    MEM_REN,
    output logic [ADDR_WIDTH-1:0]   MEM_ARADDR,
    input  logic [DATA_WIDTH-1:0]   MEM_RDATA
);

    localparam int STRB_W = DATA_WIDTH / 8;

`ifdef AXIL_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic awready_q, awready_d;
    logic wready_q, wready_d;
    logic arready_q, arready_d;

    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs;
    logic aw_err, ar_err;

    logic [ADDR_WIDTH-1:0]        aw_addr;
    logic [ADDR_WIDTH-1:0]        ar_addr;
    logic [STRB_W+DATA_WIDTH-1:0] w_held;

    assign aw_hs = S_AWVALID && awready_q;
    assign w_hs  = S_WVALID && wready_q;
    assign ar_hs = S_ARVALID && arready_q;

    axil_chan_reg #(.WIDTH(ADDR_WIDTH)) u_aw_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (aw_hs),
        .clear_i (wr_state_q == W_MEM),
        .data_i  (S_AWADDR),
        .data_o  (aw_addr)
    );

    axil_chan_reg #(.WIDTH(STRB_W + DATA_WIDTH)) u_w_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (w_hs),
        .clear_i (wr_state_q == W_MEM),
        .data_i  ({S_WSTRB, S_WDATA}),
        .data_o  (w_held)
    );

    axil_chan_reg #(.WIDTH(ADDR_WIDTH)) u_ar_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ar_hs),
        .clear_i (rd_state_q == R_WAIT),
        .data_i  (S_ARADDR),
        .data_o  (ar_addr)
    );

    // Word index is addr[ADDR_WIDTH-1:2]; the byte offset never affects the range check.
    assign aw_err = SLVERR_EN && ((aw_addr >> 2) >= ADDR_WIDTH'(DEPTH));
    assign ar_err = SLVERR_EN && ((ar_addr >> 2) >= ADDR_WIDTH'(DEPTH));

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = W_MEM;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    wr_state_d = W_MEM;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    wr_state_d = W_MEM;
                end
            end
            W_MEM: begin
                wr_state_d = W_RESP;
                bresp_d    = aw_err ? RESP_SLVERR : RESP_OKAY;
            end
            W_RESP: begin
                if (S_BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Readies are flopped from the next state, so the valid inputs never reach them combinationally.
    assign awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_D);
    assign wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_A);
    assign arready_d = (rd_state_d == R_IDLE);

    always_comb begin
        rd_state_d = rd_state_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_REQ;
                end
            end
            R_REQ: begin
                rd_state_d = R_WAIT;
            end
            R_WAIT: begin
                rd_state_d = R_RESP;
                rresp_d    = ar_err ? RESP_SLVERR : RESP_OKAY;
                rdata_d    = ar_err ? '0 : MEM_RDATA;
            end
            R_RESP: begin
                if (S_RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            arready_q  <= 1'b1;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_ARREADY = arready_q;

    assign S_BVALID = (wr_state_q == W_RESP);
    assign S_BRESP  = bresp_q;
    assign S_RVALID = (rd_state_q == R_RESP);
    assign S_RRESP  = rresp_q;
    assign S_RDATA  = rdata_q;

    assign MEM_WEN    = (wr_state_q == W_MEM) && !aw_err;
    assign MEM_AWADDR = aw_addr;
    assign MEM_WSTRB  = w_held[STRB_W+DATA_WIDTH-1:DATA_WIDTH];
    assign MEM_WDATA  = w_held[DATA_WIDTH-1:0];

    assign MEM_REN    = (rd_state_q == R_REQ) && !ar_err;
    assign MEM_ARADDR = ar_addr;

endmodule

// File: tb/tb_axil_slave_ctrl.sv
// Self-checking bench for axil_slave_ctrl: directed sequences, a vector table
// and randomized transactions checked against a word-array memory model.
module tb_axil_slave_ctrl;

    localparam int DEPTH = 256;
`ifdef AXIL_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        S_AWVALID, S_AWREADY;
    logic [31:0] S_AWADDR;
    logic        S_WVALID, S_WREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_BVALID, S_BREADY;
    logic [1:0]  S_BRESP;
    logic        S_ARVALID, S_ARREADY;
    logic [31:0] S_ARADDR;
    logic        S_RVALID, S_RREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        MEM_WEN, MEM_REN;
    logic [31:0] MEM_AWADDR, MEM_WDATA, MEM_ARADDR, MEM_RDATA;
    logic [3:0]  MEM_WSTRB;

    int total = 0;
    int bad   = 0;

    axil_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .S_AWVALID  (S_AWVALID),
        .S_AWREADY  (S_AWREADY),
        .S_AWADDR   (S_AWADDR),
        .S_WVALID   (S_WVALID),
        .S_WREADY   (S_WREADY),
        .S_WDATA    (S_WDATA),
        .S_WSTRB    (S_WSTRB),
        .S_BVALID   (S_BVALID),
        .S_BREADY   (S_BREADY),
        .S_BRESP    (S_BRESP),
        .S_ARVALID  (S_ARVALID),
        .S_ARREADY  (S_ARREADY),
        .S_ARADDR   (S_ARADDR),
        .S_RVALID   (S_RVALID),
        .S_RREADY   (S_RREADY),
        .S_RDATA    (S_RDATA),
        .S_RRESP    (S_RRESP),
        .MEM_WEN    (MEM_WEN),
        .MEM_AWADDR (MEM_AWADDR),
        .MEM_WSTRB  (MEM_WSTRB),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_REN    (MEM_REN),
        .MEM_ARADDR (MEM_ARADDR),
        .MEM_RDATA  (MEM_RDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 3)   return 32'h1234_5678;
        if (i == 256) return 32'hCAFE_0400;
        return 32'(i) * 32'h9E37_79B9;
    endfunction

    // Downstream memory: write on MEM_WEN, read data one cycle after MEM_REN.
    logic [31:0] tb_mem [1024];
    logic        mem_init;
    int          wen_cnt = 0;
    int          ren_cnt = 0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
        end else if (MEM_WEN) begin
            for (int b = 0; b < 4; b++)
                if (MEM_WSTRB[b]) tb_mem[MEM_AWADDR[11:2]][8*b +: 8] <= MEM_WDATA[8*b +: 8];
        end
        if (MEM_REN) MEM_RDATA <= tb_mem[MEM_ARADDR[11:2]];
        if (MEM_WEN) wen_cnt <= wen_cnt + 1;
        if (MEM_REN) ren_cnt <= ren_cnt + 1;
    end

    // Reference: what each word should contain after all accepted writes.
    logic [31:0] ref_mem [1024];

    function automatic logic [1:0] model_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
        int idx = int'(addr[11:2]);
        if (SLVERR_EN && (addr >> 2) >= DEPTH) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        return 2'b00;
    endfunction

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        if (SLVERR_EN && (addr >> 2) >= DEPTH) begin
            data = 32'h0;
            resp = 2'b10;
        end else begin
            data = ref_mem[addr[11:2]];
            resp = 2'b00;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // w_lead > 0: W offered that many cycles before AW; < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int b_delay, input logic [1:0] exp_resp);
        bit aw_done, w_done, aw_hs, w_hs, err;
        int cyc, t_aw, t_w, wen0;
        err  = (exp_resp == 2'b10);
        t_aw = (w_lead > 0) ? w_lead : 0;
        t_w  = (w_lead < 0) ? -w_lead : 0;
        wen0 = wen_cnt;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        S_AWADDR = addr;
        S_WDATA  = data;
        S_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (w_done && !aw_done) check("wready_while_waiting", S_WREADY, 1'b0);
            if (aw_done && !w_done) check("awready_while_waiting", S_AWREADY, 1'b0);
            S_AWVALID = !aw_done && cyc >= t_aw;
            S_WVALID  = !w_done && cyc >= t_w;
            aw_hs = S_AWVALID && S_AWREADY;
            w_hs  = S_WVALID && S_WREADY;
            tick();
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        check("aw_w_accepted", {aw_done, w_done}, 2'b11);
        check("mem_wen_lat", MEM_WEN, !err);
        if (!err) check("mem_wr_bus", {MEM_AWADDR, MEM_WSTRB, MEM_WDATA}, {addr, strb, data});
        tick();
        check("bvalid_lat", {S_BVALID, S_BRESP}, {1'b1, exp_resp});
        for (int i = 0; i < b_delay; i++) begin
            tick();
            check("bvalid_hold", {S_BVALID, S_BRESP}, {1'b1, exp_resp});
        end
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        check("b_done_ready", {S_BVALID, S_AWREADY, S_WREADY}, 3'b011);
        check("wen_count", wen_cnt - wen0, err ? 0 : 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_delay,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int lat, ren0;
        bit err;
        err  = (exp_resp == 2'b10);
        ren0 = ren_cnt;
        S_ARADDR  = addr;
        S_ARVALID = 1'b1;
        lat = 0;
        while (!S_ARREADY && lat < 50) begin
            tick();
            lat++;
        end
        check("arready", S_ARREADY, 1'b1);
        tick();
        S_ARVALID = 1'b0;
        check("mem_ren_lat", MEM_REN, !err);
        if (!err) check("mem_araddr", MEM_ARADDR, addr);
        lat = 1;
        while (!S_RVALID && lat < 20) begin
            tick();
            lat++;
        end
        check("rvalid_lat", lat, 3);
        check("rdata_rresp", {S_RRESP, S_RDATA}, {exp_resp, exp_data});
        for (int i = 0; i < r_delay; i++) begin
            tick();
            check("rvalid_hold", {S_RVALID, S_RRESP, S_RDATA}, {1'b1, exp_resp, exp_data});
        end
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
        check("r_done_ready", {S_RVALID, S_ARREADY}, 2'b01);
        check("ren_count", ren_cnt - ren0, err ? 0 : 1);
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, exp_d;
        logic [3:0]  s;
        logic [1:0]  exp_r, exp_wr;
        int wen0, ren0;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 32'h12,  32'h1122_3344, 4'h5, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 32'h10,  32'h0,         4'h0, 2'b00, 32'hDE22_BE44};
        vecs[3]  = '{1'b1, 32'h13,  32'hAABB_CCDD, 4'h8, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h11,  32'h0,         4'h0, 2'b00, 32'hAA22_BE44};
        vecs[5]  = '{1'b0, 32'h0C,  32'h0,         4'h0, 2'b00, 32'hAA34_9983};
        vecs[6]  = '{1'b0, 32'h23,  32'h0,         4'h0, 2'b00, 32'h0BAD_F00D};
        vecs[7]  = '{1'b1, 32'h3FC, 32'h0102_0304, 4'hF, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 32'h3FC, 32'h0,         4'h0, 2'b00, 32'h0102_0304};
        vecs[9]  = '{1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, SLVERR_EN ? 2'b10 : 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h400, 32'h0,         4'h0, SLVERR_EN ? 2'b10 : 2'b00,
                     SLVERR_EN ? 32'h0 : 32'hFFFF_FFFF};
        vecs[11] = '{1'b1, 32'h0,   32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h0,   32'h0,         4'h0, 2'b00, 32'h0};

        reset = 1'b1;
        mem_init = 1'b1;
        {S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY} = '0;
        S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0; S_ARADDR = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        repeat (3) tick();
        reset = 1'b0;
        mem_init = 1'b0;

        check("rst_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);
        check("rst_valid", {S_BVALID, S_RVALID, MEM_WEN, MEM_REN}, 4'b0000);
        check("rst_resp_data", {S_BRESP, S_RRESP, S_RDATA}, '0);
        check("rst_mem_bus", {MEM_AWADDR, MEM_WSTRB, MEM_WDATA, MEM_ARADDR}, '0);
        tick();

        // Read of a preloaded word, response held four cycles without RREADY.
        do_read(32'h0C, 4, 32'h1234_5678, 2'b00);

        // Same-cycle AW+W with partial strobes.
        void'(model_write(32'h0C, 32'hAA01_9983, 4'b1011));
        do_write(32'h0C, 32'hAA01_9983, 4'b1011, 0, 0, 2'b00);

        // W accepted three cycles ahead of AW.
        void'(model_write(32'h20, 32'h0BAD_F00D, 4'hF));
        do_write(32'h20, 32'h0BAD_F00D, 4'hF, 3, 1, 2'b00);

        // First word beyond DEPTH.
        do_read(32'h400, 1, SLVERR_EN ? 32'h0 : 32'hCAFE_0400, SLVERR_EN ? 2'b10 : 2'b00);

        // Reset while only AW is held: nothing may reach memory or the B channel.
        S_AWADDR  = 32'h40;
        S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        check("have_a_ready", {S_AWREADY, S_WREADY}, 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wen0 = wen_cnt;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_quiet", {S_BVALID, MEM_WEN, S_AWREADY, S_WREADY}, 4'b0011);
            tick();
        end
        check("rst_mid_no_wen", wen_cnt - wen0, 0);
        void'(model_write(32'h40, 32'h5555_AAAA, 4'hF));
        do_write(32'h40, 32'h5555_AAAA, 4'hF, 2, 0, 2'b00);

        // Concurrent read and write issue in the same cycle.
        exp_wr = model_write(32'h44, 32'h7777_1111, 4'hF);
        model_read(32'h20, exp_d, exp_r);
        wen0 = wen_cnt;
        ren0 = ren_cnt;
        S_AWADDR = 32'h44; S_WDATA = 32'h7777_1111; S_WSTRB = 4'hF; S_ARADDR = 32'h20;
        {S_AWVALID, S_WVALID, S_ARVALID} = 3'b111;
        tick();
        {S_AWVALID, S_WVALID, S_ARVALID} = 3'b000;
        check("conc_wen_ren", {MEM_WEN, MEM_REN}, 2'b11);
        tick();
        check("conc_bvalid", {S_BVALID, S_BRESP, S_RVALID}, {1'b1, exp_wr, 1'b0});
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        check("conc_rvalid", {S_BVALID, S_RVALID, S_RRESP, S_RDATA}, {1'b0, 1'b1, exp_r, exp_d});
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
        check("conc_counts", {wen_cnt - wen0, ren_cnt - ren0}, {32'd1, 32'd1});

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, (i % 3) - 1, i % 2, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, i % 3, vecs[i].exp_rdata, vecs[i].exp_resp);
            end
        end

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom_range(32'h400, 32'h7FF);
            else                           a = $urandom_range(0, 32'h3FF);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_wr = model_write(a, d, s);
                do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), exp_wr);
            end else begin
                model_read(a, exp_d, exp_r);
                do_read(a, int'($urandom_range(0, 3)), exp_d, exp_r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
